// File: rtl/fir_decim_buffer.sv
// Block-averaging decimator for the 3-tap FIR output, followed by a small
// show-ahead FIFO drained through a valid/ready handshake.
module fir_decim_buffer #(
  parameter int LOG2_DECIM = 2,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int AW    = 8 + LOG2_DECIM;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]       FULL_C      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]       EMPTY_C     = {(ADDR_W+1){1'b0}};
  localparam logic [LOG2_DECIM-1:0] SCNT_LAST_C = {LOG2_DECIM{1'b1}};
  localparam logic [LOG2_DECIM-1:0] SCNT_ZERO_C = {LOG2_DECIM{1'b0}};

  logic [LOG2_DECIM-1:0] scnt_q, scnt_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic [7:0]            mem_q [DEPTH];

  logic [AW-1:0]         sum_s;
  logic [7:0]            res_s;
  logic [ADDR_W-1:0]     rd_next_s;
  logic                  block_end_s, empty_s, full_s, pop_s, push_s, drop_s;

  // Sum is full width so the block total can never wrap.
  assign sum_s       = acc_q + {{LOG2_DECIM{1'b0}}, din};
  assign res_s       = sum_s[AW-1:LOG2_DECIM];
  assign block_end_s = din_valid && (scnt_q == SCNT_LAST_C);
  assign empty_s     = (count_q == EMPTY_C);
  assign full_s      = (count_q == FULL_C);
  assign pop_s       = !empty_s && dout_ready;
  assign push_s      = block_end_s && (!full_s || pop_s);
  assign drop_s      = block_end_s && full_s && !pop_s;
  assign rd_next_s   = rd_ptr_q + ADDR_W'(1'b1);

  // Sample counter and accumulator next state.
  always_comb begin
    scnt_d = scnt_q;
    acc_d  = acc_q;
    if (din_valid) begin
      scnt_d = scnt_q + LOG2_DECIM'(1'b1);
      if (scnt_q == SCNT_ZERO_C) begin
        acc_d = {{LOG2_DECIM{1'b0}}, din};
      end else begin
        acc_d = sum_s;
      end
    end else begin
      scnt_d = scnt_q;
      acc_d  = acc_q;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and registered head.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + ADDR_W'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_next_s : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1'b1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1'b1);
      default: count_d = count_q;
    endcase

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // A push into an empty FIFO, or into one whose only entry is leaving, becomes the head.
    dout_d = dout_q;
    if (push_s && (empty_s || (pop_s && count_q == (ADDR_W+1)'(1'b1)))) begin
      dout_d = res_s;
    end else if (pop_s && count_q != (ADDR_W+1)'(1'b1)) begin
      dout_d = mem_q[rd_next_s];
    end else begin
      dout_d = dout_q;
    end

    dvalid_d = (count_d != EMPTY_C);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scnt_q   <= SCNT_ZERO_C;
      acc_q    <= {AW{1'b0}};
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= EMPTY_C;
      ovf_q    <= 1'b0;
      dout_q   <= 8'd0;
      dvalid_q <= 1'b0;
    end else begin
      scnt_q   <= scnt_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= res_s;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dvalid_q;
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule
